// File: rtl/zircon_avalon_vga_flip_ctrl_if.sv
// Avalon-MM slave bus bundle for the VGA page-flip controller.
// master modport: bus initiator (CPU side or testbench).
// slave modport : zircon_avalon_vga_flip_ctrl.
//   avs_address   3-bit register word offset
//   avs_write     write strobe, avs_writedata 32-bit write data
//   avs_read      read strobe,  avs_readdata  32-bit read data (latency 1)
interface zircon_avalon_vga_flip_ctrl_if;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/zircon_avalon_vga_flip_ctrl.sv
// Double-buffer page-flip scheduler for the VGA frame reader.
// Holds two frame-buffer base addresses; swaps the displayed buffer only on a
// frame-start edge so a frame is never torn mid-scan.
// Ports:
//   csi_clk, rsi_reset_n      clock, synchronous active-low reset
//   avs (slave modport)       Avalon-MM register port, read latency 1
//   vga_frame_start           frame-start level from VGA timing
//   vga_buffer_address        active buffer base address to the reader
//   vga_start                 frame reader enable
//   ins_irq                   end-of-flip interrupt, level, active-high
// Build option: define VGA_FLIP_IRQ_EN to implement irq_en/irq_flag/ins_irq;
// otherwise those bits read 0, ignore writes, and ins_irq stays 0.
module zircon_avalon_vga_flip_ctrl #(
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                            csi_clk,
  input  logic                            rsi_reset_n,
  zircon_avalon_vga_flip_ctrl_if.slave    avs,
  input  logic                            vga_frame_start,
  output logic [31:0]                     vga_buffer_address,
  output logic                            vga_start,
  output logic                            ins_irq
);

  typedef enum logic [1:0] {StStopped, StWaitSof, StRun} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            buf0_q, buf0_d, buf1_q, buf1_d;
  logic                   enable_q, enable_d, irq_en_q, irq_en_d;
  logic                   front_q, front_d, pending_q, pending_d;
  logic                   irq_flag_q, irq_flag_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   sof_d_q;
  logic [31:0]            addr_q, addr_d;
  logic                   start_q, start_d, irq_q, irq_d;
  logic [31:0]            readdata_q, readdata_d;

  logic        sof, run_sof;
  logic        wr_buf0, wr_buf1, wr_ctrl, wr_flip, wr_status;
  logic [31:0] rd_mux;

  assign sof       = vga_frame_start & ~sof_d_q;
  assign wr_buf0   = avs.avs_write && (avs.avs_address == 3'd0);
  assign wr_buf1   = avs.avs_write && (avs.avs_address == 3'd1);
  assign wr_ctrl   = avs.avs_write && (avs.avs_address == 3'd2);
  assign wr_flip   = avs.avs_write && (avs.avs_address == 3'd3);
  assign wr_status = avs.avs_write && (avs.avs_address == 3'd4);

  always_comb begin
    rd_mux = 32'd0;
    unique case (avs.avs_address)
      3'd0:    rd_mux = buf0_q;
      3'd1:    rd_mux = buf1_q;
      3'd2:    rd_mux = {30'd0, irq_en_q, enable_q};
      3'd4:    rd_mux = {16'(frame_cnt_q), 13'd0, irq_flag_q, pending_q, front_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    front_d     = front_q;
    pending_d   = pending_q;
    irq_flag_d  = irq_flag_q;
    frame_cnt_d = frame_cnt_q;
    run_sof     = 1'b0;

    if (wr_buf0) buf0_d = avs.avs_writedata;
    if (wr_buf1) buf1_d = avs.avs_writedata;
    if (wr_ctrl) begin
      enable_d = avs.avs_writedata[0];
`ifdef VGA_FLIP_IRQ_EN
      irq_en_d = avs.avs_writedata[1];
`endif
    end
    // A flip request while one is already pending is dropped, never queued.
    if (wr_flip && avs.avs_writedata[0] && !pending_q) pending_d = 1'b1;
`ifdef VGA_FLIP_IRQ_EN
    if (wr_status && avs.avs_writedata[2]) irq_flag_d = 1'b0;
`endif

    // Disable acts on the written value so the reader stops one cycle after the write.
    unique case (state_q)
      StStopped: begin
        if (enable_d) state_d = StWaitSof;
      end
      StWaitSof: begin
        if (!enable_d) begin
          state_d   = StStopped;
          pending_d = 1'b0;
        end else if (sof) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!enable_d) begin
          state_d   = StStopped;
          pending_d = 1'b0;
        end else if (sof) begin
          run_sof = 1'b1;
        end
      end
      default: state_d = StStopped;
    endcase

    // Only pending_q counts here: a flip written in this sof cycle waits one frame.
    if (run_sof) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      if (pending_q) begin
        front_d   = ~front_q;
        pending_d = 1'b0;
`ifdef VGA_FLIP_IRQ_EN
        irq_flag_d = 1'b1;  // set wins over a same-cycle W1C
`endif
      end
    end

    // Outside RUN the address tracks the front buffer; in RUN it re-latches only on sof.
    if (state_d != StRun || state_q != StRun || run_sof) begin
      addr_d = front_d ? buf1_d : buf0_d;
    end else begin
      addr_d = addr_q;
    end
    start_d    = (state_d == StRun);
    irq_d      = irq_flag_d & irq_en_d;
    readdata_d = avs.avs_read ? rd_mux : readdata_q;
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_q     <= StStopped;
      buf0_q      <= 32'd0;
      buf1_q      <= 32'd0;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      front_q     <= 1'b0;
      pending_q   <= 1'b0;
      irq_flag_q  <= 1'b0;
      frame_cnt_q <= '0;
      sof_d_q     <= 1'b0;
      addr_q      <= 32'd0;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      front_q     <= front_d;
      pending_q   <= pending_d;
      irq_flag_q  <= irq_flag_d;
      frame_cnt_q <= frame_cnt_d;
      sof_d_q     <= vga_frame_start;
      addr_q      <= addr_d;
      start_q     <= start_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign vga_buffer_address = addr_q;
  assign vga_start          = start_q;
  assign ins_irq            = irq_q;
  assign avs.avs_readdata   = readdata_q;

endmodule
